// File: rtl/sa_pkg.sv
// sa_pkg: shared FSM state type, fixed-point default and accumulator
// width helper for the sa_responder systolic array.
package sa_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FEED,
        S_SHIFT,
        S_DONE
    } state_e;

    localparam int FRAC_DEF = 5;

    // Headroom for 128 full-scale products without overflow.
    function automatic int acc_w(input int d_w);
        return 2 * d_w + 8;
    endfunction

endpackage

// File: rtl/sa_pe.sv
// sa_pe: one systolic processing element -- signed multiply-accumulate
// with registered east/south operand forwarding and synchronous clear.
module sa_pe
    import sa_pkg::*;
#(
    parameter int D_W   = 8,
    parameter int ACC_W = acc_w(D_W)
) (
    input  logic                    clk_i,
    input  logic                    clr_i,
    input  logic                    en_i,
    input  logic signed [D_W-1:0]   a_i,
    input  logic signed [D_W-1:0]   b_i,
    output logic signed [D_W-1:0]   a_o,
    output logic signed [D_W-1:0]   b_o,
    output logic signed [ACC_W-1:0] acc_o
);

    logic signed [D_W-1:0]   a_q;
    logic signed [D_W-1:0]   b_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [2*D_W-1:0] prod;
    logic signed [ACC_W-1:0] prod_ext;

    assign prod     = a_i * b_i;
    assign prod_ext = {{(ACC_W - 2 * D_W){prod[2*D_W-1]}}, prod};

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else if (en_i) begin
            a_q   <= a_i;
            b_q   <= b_i;
            acc_q <= acc_q + prod_ext;
        end
    end

    assign a_o   = a_q;
    assign b_o   = b_q;
    assign acc_o = acc_q;

endmodule

// File: rtl/sa_responder.sv
// sa_responder: SA_R x SA_C output-stationary systolic matrix multiplier.
// Define SA_SAT_EN to saturate results instead of two's-complement wrap.
module sa_responder
    import sa_pkg::*;
#(
    parameter int D_W   = 8,
    parameter int SA_R  = 16,
    parameter int SA_C  = 16,
    parameter int K_MAX = 128,
    parameter int FRAC  = FRAC_DEF
) (
    input  logic                                     I_CLK,
    input  logic                                     I_SYNC_RST,
    input  logic                                     I_START,
    input  logic [0:SA_R-1][0:K_MAX-1][D_W-1:0]      I_MAT_1,
    input  logic [0:K_MAX-1][0:SA_C-1][D_W-1:0]      I_MAT_2,
    input  logic [7:0]                               I_M_DIM,
    output logic                                     O_PE_SHIFT,
    output logic                                     O_VLD,
    output logic [0:SA_R-1][0:SA_C-1][D_W-1:0]       O_RESULT
);

    localparam int ACC_W = acc_w(D_W);
    localparam int K_W   = $clog2(K_MAX);
    localparam int M_W   = $clog2(K_MAX + 1);
    localparam int T_W   = $clog2(K_MAX + SA_R + SA_C);

`ifdef SA_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((1 << (D_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = -SAT_HI - 1;
`endif

    state_e           state_q;
    logic [M_W-1:0]   m_q;
    logic [M_W-1:0]   m_d;
    logic [T_W-1:0]   t_q;
    logic [T_W-1:0]   t_last;
    logic             feed;
    logic             clr;
    logic             unused_edge;

    logic signed [D_W-1:0]   a_h [SA_R][SA_C+1];
    logic signed [D_W-1:0]   b_v [SA_R+1][SA_C];
    logic signed [ACC_W-1:0] acc [SA_R][SA_C];

    function automatic logic [D_W-1:0] scale(input logic signed [ACC_W-1:0] a);
`ifdef SA_SAT_EN
        logic signed [ACC_W-1:0] sh;
        sh = a >>> FRAC;
        if (sh > SAT_HI) return SAT_HI[D_W-1:0];
        if (sh < SAT_LO) return SAT_LO[D_W-1:0];
        return sh[D_W-1:0];
`else
        return D_W'(a >>> FRAC);
`endif
    endfunction

    assign m_d    = (int'(I_M_DIM) > K_MAX) ? M_W'(K_MAX) : M_W'(I_M_DIM);
    assign t_last = T_W'(m_q) + T_W'(SA_R + SA_C - 3);
    assign feed   = (state_q == S_FEED);
    assign clr    = I_SYNC_RST || (state_q == S_LOAD);

    // Skewed edge injection: row i lags by i cycles, column j by j.
    for (genvar i = 0; i < SA_R; i++) begin : g_west
        logic [T_W-1:0] k;
        assign k = t_q - T_W'(i);
        assign a_h[i][0] = (feed && t_q >= T_W'(i) && k < T_W'(m_q))
                         ? I_MAT_1[i][k[K_W-1:0]] : '0;
    end

    for (genvar j = 0; j < SA_C; j++) begin : g_north
        logic [T_W-1:0] k;
        assign k = t_q - T_W'(j);
        assign b_v[0][j] = (feed && t_q >= T_W'(j) && k < T_W'(m_q))
                         ? I_MAT_2[k[K_W-1:0]][j] : '0;
    end

    for (genvar i = 0; i < SA_R; i++) begin : g_r
        for (genvar j = 0; j < SA_C; j++) begin : g_c
            sa_pe #(
                .D_W  (D_W),
                .ACC_W(ACC_W)
            ) u_pe (
                .clk_i(I_CLK),
                .clr_i(clr),
                .en_i (feed),
                .a_i  (a_h[i][j]),
                .b_i  (b_v[i][j]),
                .a_o  (a_h[i][j+1]),
                .b_o  (b_v[i+1][j]),
                .acc_o(acc[i][j])
            );
        end
    end

    always_comb begin
        unused_edge = 1'b0;
        for (int i = 0; i < SA_R; i++) unused_edge = unused_edge ^ (^a_h[i][SA_C]);
        for (int j = 0; j < SA_C; j++) unused_edge = unused_edge ^ (^b_v[SA_R][j]);
    end

    always_ff @(posedge I_CLK) begin
        if (I_SYNC_RST) begin
            state_q    <= S_IDLE;
            m_q        <= '0;
            t_q        <= '0;
            O_PE_SHIFT <= 1'b0;
            O_VLD      <= 1'b0;
            O_RESULT   <= '0;
        end else begin
            O_PE_SHIFT <= 1'b0;
            O_VLD      <= 1'b0;
            unique case (state_q)
                S_IDLE: if (I_START) state_q <= S_LOAD;
                S_LOAD: begin
                    m_q     <= m_d;
                    t_q     <= '0;
                    state_q <= S_FEED;
                end
                S_FEED: begin
                    if (t_q == t_last) state_q <= S_SHIFT;
                    else               t_q     <= t_q + 1'b1;
                end
                S_SHIFT: begin
                    for (int i = 0; i < SA_R; i++)
                        for (int j = 0; j < SA_C; j++)
                            O_RESULT[i][j] <= scale(acc[i][j]);
                    O_PE_SHIFT <= 1'b1;
                    state_q    <= S_DONE;
                end
                S_DONE: begin
                    O_VLD   <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
